// File: rtl/ncl_pkg.sv
// Shared types and helpers for the clocked/NCL boundary stages.
// Dual-rail encoding and the source-side state encoding.
package ncl_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WAIT_RFN,
    WAIT_RFD,
    ERROR
  } src_state_t;

  localparam int TIMER_W  = 16;
  localparam int DR_MAX_W = 32;

  // Returns {t, f}; callers slice the low WIDTH bits of each half.
  function automatic logic [2*DR_MAX_W-1:0] dr_encode(
    input logic [DR_MAX_W-1:0] word
  );
    return {word, ~word};
  endfunction

endpackage

// File: rtl/ncl_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
// Reusable by both the source and the sink side of the NCL pipe.
module ncl_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input one stage deeper each cycle.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Chain register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ncl_dr_source.sv
// Clocked-to-NCL source: turns valid/ready words into dual-rail
// DATA/NULL wavefronts paced by the synchronized ki acknowledge.
module ncl_dr_source
  import ncl_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] d_t,
  output logic [WIDTH-1:0] d_f,
  input  logic             ki,
  output logic             err,
  output logic             busy
);

  localparam logic [TIMER_W-1:0] TO_VAL = TIMER_W'(TIMEOUT);

  src_state_t         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] timer_inc;
  logic [WIDTH-1:0]   t_q, t_d;
  logic [WIDTH-1:0]   f_q, f_d;
  logic               ki_s;
  logic               timed_out;

  ncl_sync #(
    .STAGES(SYNC_STAGES)
  ) u_ki_sync (
    .clk(clk),
    .rst(rst),
    .d  (ki),
    .q  (ki_s)
  );

  // Next state, timer and rails; rails only move on state entry.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    t_d       = t_q;
    f_d       = f_q;
    timer_inc = timer_q + TIMER_W'(1);
    timed_out = (timer_inc == TO_VAL);
    unique case (state_q)
      INIT: begin
        t_d = '0;
        f_d = '0;
        if (ki_s) state_d = IDLE;
      end
      IDLE: begin
        if (in_valid) begin
          t_d = WIDTH'(dr_encode(DR_MAX_W'(in_data)) >> DR_MAX_W);
          f_d = WIDTH'(dr_encode(DR_MAX_W'(in_data)));
          timer_d = '0;
          state_d = WAIT_RFN;
        end
      end
      WAIT_RFN: begin
        if (!ki_s) begin
          t_d     = '0;
          f_d     = '0;
          timer_d = '0;
          state_d = WAIT_RFD;
        end else if (timed_out) begin
          t_d     = '0;
          f_d     = '0;
          state_d = ERROR;
        end else begin
          timer_d = timer_inc;
        end
      end
      WAIT_RFD: begin
        if (ki_s) begin
          state_d = IDLE;
        end else if (timed_out) begin
          state_d = ERROR;
        end else begin
          timer_d = timer_inc;
        end
      end
      ERROR: begin
        t_d = '0;
        f_d = '0;
      end
      default: begin
        t_d     = '0;
        f_d     = '0;
        state_d = INIT;
      end
    endcase
  end

  // State, timer and rail registers; reset forces NULL at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      timer_q <= '0;
      t_q     <= '0;
      f_q     <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      t_q     <= t_d;
      f_q     <= f_d;
    end
  end

  assign d_t      = t_q;
  assign d_f      = f_q;
  assign in_ready = (state_q == IDLE);
  assign err      = (state_q == ERROR);
  assign busy     = (state_q != INIT) && (state_q != IDLE);

endmodule

// File: tb/tb_ncl_dr_source.sv
// Directed bench for ncl_dr_source with a combinational TH-stage
// acknowledge model and a manual ki drive for protocol corner cases.
module tb_ncl_dr_source;

  localparam int W = 3;

  logic         clk      = 1'b0;
  logic         rst      = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data  = '0;
  logic         in_ready;
  logic [W-1:0] d_t;
  logic [W-1:0] d_f;
  logic         ki;
  logic         err;
  logic         busy;

  logic ki_mode = 1'b0;
  logic ki_man  = 1'b0;
  logic ki_model;

  int compared   = 0;
  int mismatched = 0;
  int illegal    = 0;
  int cyc        = 0;

  logic [W-1:0] acc_q[$];
  logic [W-1:0] seen_q[$];
  logic         prev_null = 1'b1;

  always #5 clk = ~clk;

  // TH stage: rfn once every bit carries data, rfd once all NULL.
  assign ki_model = ((d_t | d_f) != 3'b111);
  assign ki       = ki_mode ? ki_model : ki_man;

  ncl_dr_source #(
    .WIDTH      (W),
    .TIMEOUT    (10),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .d_t     (d_t),
    .d_f     (d_f),
    .ki      (ki),
    .err     (err),
    .busy    (busy)
  );

  always @(posedge clk) begin
    cyc++;
    if (!rst && in_valid && in_ready) acc_q.push_back(in_data);
  end

  always @(negedge clk) begin
    if ((d_t & d_f) != '0) illegal++;
    if (prev_null && ((d_t | d_f) != '0)) seen_q.push_back(d_t);
    prev_null = ((d_t | d_f) == '0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; ki_mode = 1'b0; ki_man = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({d_t, d_f, in_ready, err, busy} !== 9'b0) begin
      mismatched++;
      $display("FAIL reset_outs: got %b expected %b",
               {d_t, d_f, in_ready, err, busy}, 9'b0);
    end
    ki_man = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL init_hold: got %b expected 0", in_ready);
    end
    @(negedge clk);
    compared++;
    if ({in_ready, busy, d_t, d_f} !== 8'b1000_0000) begin
      mismatched++;
      $display("FAIL init_idle: got %b expected %b",
               {in_ready, busy, d_t, d_f}, 8'b1000_0000);
    end
  endtask

  task automatic test_single();
    int n;
    ki_mode = 1'b1;
    in_data = 3'b101; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    compared++;
    if ({d_t, d_f, in_ready, busy} !== {3'b101, 3'b010, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL single_data: got %b expected %b",
               {d_t, d_f, in_ready, busy}, {3'b101, 3'b010, 1'b0, 1'b1});
    end
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        compared++;
        if ({d_t, d_f} !== 6'b101_010) begin
          mismatched++;
          $display("FAIL single_hold: got %b expected 101010", {d_t, d_f});
        end
      end
      if (n == 3) begin
        compared++;
        if ({d_t, d_f} !== 6'b0) begin
          mismatched++;
          $display("FAIL single_null: got %b expected 000000", {d_t, d_f});
        end
      end
    end
    compared++;
    if (n !== 6) begin
      mismatched++;
      $display("FAIL single_cycle: got %0d clocks expected 6", n);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w[3];
    int t_acc[3];
    int n;
    w[0] = 3'd0; w[1] = 3'd7; w[2] = 3'd3;
    ki_mode = 1'b1;
    acc_q.delete();
    seen_q.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = w[i];
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      t_acc[i] = cyc;
      compared++;
      if ({d_t, d_f} !== {w[i], ~w[i]}) begin
        mismatched++;
        $display("FAIL b2b_word%0d: got %b expected %b",
                 i, {d_t, d_f}, {w[i], ~w[i]});
      end
    end
    in_valid = 1'b0;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 1; i < 3; i++) begin
      compared++;
      if (t_acc[i] - t_acc[i-1] !== 7) begin
        mismatched++;
        $display("FAIL b2b_gap%0d: got %0d expected 7",
                 i, t_acc[i] - t_acc[i-1]);
      end
    end
    compared++;
    if (acc_q.size() !== 3 || seen_q.size() !== 3) begin
      mismatched++;
      $display("FAIL b2b_count: got acc %0d seen %0d expected 3 3",
               acc_q.size(), seen_q.size());
    end
    if (acc_q.size() == 3 && seen_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (acc_q[i] !== w[i] || seen_q[i] !== w[i]) begin
          mismatched++;
          $display("FAIL b2b_order%0d: got acc %b seen %b expected %b",
                   i, acc_q[i], seen_q[i], w[i]);
        end
      end
    end
  endtask

  task automatic test_early_rfn();
    int n;
    ki_mode = 1'b0; ki_man = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL early_idle: got %b expected 1", in_ready);
    end
    in_data = 3'b100; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    compared++;
    if ({d_t, d_f} !== 6'b100_011) begin
      mismatched++;
      $display("FAIL early_data: got %b expected 100011", {d_t, d_f});
    end
    @(negedge clk);
    compared++;
    if ({d_t, d_f, busy, err} !== 8'b0000_0010) begin
      mismatched++;
      $display("FAIL early_null: got %b expected 00000010",
               {d_t, d_f, busy, err});
    end
    ki_man = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (n !== 3) begin
      mismatched++;
      $display("FAIL early_rfd: got %0d clocks expected 3", n);
    end
  endtask

  task automatic test_timeout_race();
    int n;
    ki_mode = 1'b0; ki_man = 1'b1;
    in_data = 3'b010; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    ki_man = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({d_t, d_f} !== 6'b010_101) begin
      mismatched++;
      $display("FAIL race_hold: got %b expected 010101", {d_t, d_f});
    end
    @(negedge clk);
    compared++;
    if ({err, busy, d_t, d_f} !== 8'b0100_0000) begin
      mismatched++;
      $display("FAIL race_win: got %b expected 01000000",
               {err, busy, d_t, d_f});
    end
    ki_man = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (n !== 3 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL race_idle: got %0d clocks err %b expected 3 0", n, err);
    end
  endtask

  task automatic test_timeout();
    int n;
    ki_mode = 1'b0; ki_man = 1'b1;
    in_data = 3'b110; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (err !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (n !== 10) begin
      mismatched++;
      $display("FAIL timeout_cycles: got %0d expected 10", n);
    end
    compared++;
    if ({d_t, d_f, in_ready} !== 7'b0) begin
      mismatched++;
      $display("FAIL timeout_outs: got %b expected 0000000",
               {d_t, d_f, in_ready});
    end
    ki_man = 1'b0;
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    ki_man = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    compared++;
    if ({err, in_ready, d_t, d_f} !== 8'b1000_0000) begin
      mismatched++;
      $display("FAIL timeout_sticky: got %b expected 10000000",
               {err, in_ready, d_t, d_f});
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int sz;
    ki_mode = 1'b0; ki_man = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (err !== 1'b0 || n !== 3) begin
      mismatched++;
      $display("FAIL rst_clear: got err %b clocks %0d expected 0 3", err, n);
    end
    in_data = 3'b011; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    sz = acc_q.size();
    compared++;
    if ({d_t, d_f} !== 6'b011_100) begin
      mismatched++;
      $display("FAIL rst_data: got %b expected 011100", {d_t, d_f});
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({d_t, d_f} !== 6'b0) begin
      mismatched++;
      $display("FAIL rst_async: got %b expected 000000", {d_t, d_f});
    end
    ki_man = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    compared++;
    if ({in_ready, busy, d_t, d_f} !== 8'b0) begin
      mismatched++;
      $display("FAIL rst_init: got %b expected 00000000",
               {in_ready, busy, d_t, d_f});
    end
    ki_man = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    compared++;
    if (n !== 3 || acc_q.size() !== sz || {d_t, d_f} !== 6'b0) begin
      mismatched++;
      $display("FAIL rst_rearm: got %0d clocks %0d words rails %b expected 3 %0d 0",
               n, acc_q.size(), {d_t, d_f}, sz);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_early_rfn();
    test_timeout_race();
    test_timeout();
    test_reset_mid();
    compared++;
    if (illegal !== 0) begin
      mismatched++;
      $display("FAIL both_rails: got %0d samples expected 0", illegal);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
